// File: rtl/ex_muldiv_unit_pkg.sv
// rtl/ex_muldiv_unit_pkg.sv - op codes, default width and FSM states for the EX mul/div unit
package ex_muldiv_unit_pkg;

  localparam int XLEN_DEFAULT = 64;

  localparam logic [3:0] MD_MUL    = 4'd0;
  localparam logic [3:0] MD_MULH   = 4'd1;
  localparam logic [3:0] MD_MULHSU = 4'd2;
  localparam logic [3:0] MD_MULHU  = 4'd3;
  localparam logic [3:0] MD_DIV    = 4'd4;
  localparam logic [3:0] MD_DIVU   = 4'd5;
  localparam logic [3:0] MD_REM    = 4'd6;
  localparam logic [3:0] MD_REMU   = 4'd7;
  localparam logic [3:0] MD_MULW   = 4'd8;
  localparam logic [3:0] MD_DIVW   = 4'd9;
  localparam logic [3:0] MD_DIVUW  = 4'd10;
  localparam logic [3:0] MD_REMW   = 4'd11;
  localparam logic [3:0] MD_REMUW  = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ex_muldiv_unit_core.sv
// rtl/ex_muldiv_unit_core.sv - radix-2 iteration datapath: shift-add multiply / restoring divide step
module ex_muldiv_unit_core #(
  parameter int XLEN  = 64,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                step,
  input  logic                is_div,
  input  logic [CNT_W-1:0]    cnt_init,
  input  logic [2*XLEN-1:0]   acc_init,
  input  logic [XLEN-1:0]     opnd_init,
  output logic                last,
  output logic [2*XLEN-1:0]   acc_next
);

  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opnd_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              div_q;

  logic [XLEN:0]     shifted;
  logic [XLEN:0]     sum;
  logic [XLEN-1:0]   rem_sub;
  logic              fits;

  // Divide: acc = {partial remainder, dividend/quotient}. Multiply: acc = {partial product, multiplier}.
  always_comb begin
    shifted  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    fits     = (shifted >= {1'b0, opnd_q});
    rem_sub  = shifted[XLEN-1:0] - opnd_q;
    sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    acc_next = acc_q;
    if (div_q) begin
      if (fits) acc_next = {rem_sub, acc_q[XLEN-2:0], 1'b1};
      else      acc_next = {shifted[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      acc_next = {sum, acc_q[XLEN-1:1]};
    end
  end

  assign last = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      div_q  <= 1'b0;
    end else if (start) begin
      acc_q  <= acc_init;
      opnd_q <= opnd_init;
      cnt_q  <= cnt_init;
      div_q  <= is_div;
    end else if (step) begin
      acc_q  <= acc_next;
      cnt_q  <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative RV64M multiply/divide unit: decode, sign handling, special cases, FSM
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  input  logic            hold_i,
  output logic            stall_req_o,
  output logic            result_valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CNT_W = $clog2(XLEN);
  localparam bit W_OK  = (XLEN > 32);
  localparam logic [XLEN-1:0] X_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] W_MIN = XLEN'($signed(32'h8000_0000));

  function automatic logic [XLEN-1:0] fix_w(input logic [XLEN-1:0] v, input logic w);
    return w ? XLEN'($signed(v[31:0])) : v;
  endfunction

  state_t state_q, state_d;

  logic is_w, is_div, is_rem, is_hi, rsvd, sgn_a, sgn_b;

  always_comb begin
    is_w = 1'b0; is_div = 1'b0; is_rem = 1'b0; is_hi = 1'b0;
    rsvd = 1'b0; sgn_a = 1'b0; sgn_b = 1'b0;
    case (op_i)
      MD_MUL:    begin sgn_a = 1'b1; sgn_b = 1'b1; end
      MD_MULH:   begin is_hi = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; end
      MD_MULHSU: begin is_hi = 1'b1; sgn_a = 1'b1; end
      MD_MULHU:  is_hi = 1'b1;
      MD_DIV:    begin is_div = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; end
      MD_DIVU:   is_div = 1'b1;
      MD_REM:    begin is_div = 1'b1; is_rem = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; end
      MD_REMU:   begin is_div = 1'b1; is_rem = 1'b1; end
      MD_MULW:   begin is_w = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; rsvd = !W_OK; end
      MD_DIVW:   begin is_w = 1'b1; is_div = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; rsvd = !W_OK; end
      MD_DIVUW:  begin is_w = 1'b1; is_div = 1'b1; rsvd = !W_OK; end
      MD_REMW:   begin is_w = 1'b1; is_div = 1'b1; is_rem = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; rsvd = !W_OK; end
      MD_REMUW:  begin is_w = 1'b1; is_div = 1'b1; is_rem = 1'b1; rsvd = !W_OK; end
      default:   rsvd = 1'b1;
    endcase
  end

  logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, special_res;
  logic            neg_a, neg_b, div_zero, div_ovf, fast, issue;

  always_comb begin
    a_ext = is_w ? (sgn_a ? XLEN'($signed(rs1_i[31:0])) : XLEN'(rs1_i[31:0])) : rs1_i;
    b_ext = is_w ? (sgn_b ? XLEN'($signed(rs2_i[31:0])) : XLEN'(rs2_i[31:0])) : rs2_i;
    neg_a = sgn_a & a_ext[XLEN-1];
    neg_b = sgn_b & b_ext[XLEN-1];
    mag_a = neg_a ? -a_ext : a_ext;
    mag_b = neg_b ? -b_ext : b_ext;
    div_zero = is_div & (b_ext == '0);
    div_ovf  = is_div & sgn_a & (a_ext == (is_w ? W_MIN : X_MIN)) & (&b_ext);
    fast     = rsvd | div_zero | div_ovf;
    // Divide-by-zero and MIN/-1 resolve without iterating; W results still sign-extend from bit 31.
    if (rsvd)          special_res = '0;
    else if (div_zero) special_res = is_rem ? a_ext : '1;
    else               special_res = is_rem ? '0 : a_ext;
    special_res = fix_w(special_res, is_w);
  end

  assign issue = (state_q == ST_IDLE) & valid_i & ~flush_i;

  logic [2*XLEN-1:0] acc_init, acc_next;
  logic              core_last;

  always_comb begin
    acc_init = {{XLEN{1'b0}}, mag_b};
    if (is_div) acc_init = {{XLEN{1'b0}}, (is_w ? (mag_a << 32) : mag_a)};
  end

  ex_muldiv_unit_core #(.XLEN(XLEN), .CNT_W(CNT_W)) u_core (
    .clk       (clk),
    .rst       (rst),
    .start     (issue & ~fast),
    .step      (state_q == ST_BUSY),
    .is_div    (is_div),
    .cnt_init  (is_w ? CNT_W'(31) : CNT_W'(XLEN-1)),
    .acc_init  (acc_init),
    .opnd_init (is_div ? mag_b : mag_a),
    .last      (core_last),
    .acc_next  (acc_next)
  );

  logic div_q, rem_q, hi_q, w_q, neg_res_q, neg_a_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= 1'b0; rem_q <= 1'b0; hi_q <= 1'b0; w_q <= 1'b0;
      neg_res_q <= 1'b0; neg_a_q <= 1'b0;
    end else if (issue) begin
      div_q <= is_div; rem_q <= is_rem; hi_q <= is_hi; w_q <= is_w;
      neg_res_q <= neg_a ^ neg_b; neg_a_q <= neg_a;
    end
  end

  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quot, remv, md_res;

  // W multiplies stop after 32 steps, leaving the product 32 bits up the accumulator.
  always_comb begin
    prod   = w_q ? (acc_next >> 32) : acc_next;
    prod_s = neg_res_q ? -prod : prod;
    quot   = acc_next[XLEN-1:0];
    remv   = acc_next[2*XLEN-1:XLEN];
    if (div_q) md_res = rem_q ? (neg_a_q ? -remv : remv) : (neg_res_q ? -quot : quot);
    else       md_res = hi_q ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
    md_res = fix_w(md_res, w_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_o <= '0;
    end else if (issue & fast) begin
      result_o <= special_res;
    end else if ((state_q == ST_BUSY) & core_last & ~flush_i) begin
      result_o <= md_res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (valid_i & ~flush_i) state_d = fast ? ST_DONE : ST_BUSY;
      ST_BUSY: if (core_last) state_d = ST_DONE;
      ST_DONE: if (~hold_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush_i) state_d = ST_IDLE;
  end

  assign stall_req_o    = valid_i & ~flush_i & (state_q != ST_DONE);
  assign result_valid_o = (state_q == ST_DONE) & ~flush_i;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - directed self-checking bench for ex_muldiv_unit
module tb_ex_muldiv_unit;
  import ex_muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst, valid, flush, hold;
  logic [3:0]  op;
  logic [63:0] rs1, rs2;
  logic        stall_req, result_valid;
  logic [63:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  ex_muldiv_unit #(.XLEN(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .valid_i        (valid),
    .op_i           (op),
    .rs1_i          (rs1),
    .rs2_i          (rs2),
    .flush_i        (flush),
    .hold_i         (hold),
    .stall_req_o    (stall_req),
    .result_valid_o (result_valid),
    .result_o       (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, act, exp);
    end
  endtask

  task automatic do_op(input string tag, input logic [3:0] o, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input int exp_stall, input int hold_n);
    int stalls;
    bit got;
    stalls = 0;
    got    = 1'b0;
    @(negedge clk);
    valid = 1'b1; op = o; rs1 = a; rs2 = b;
    for (int i = 0; i < 200 && !got; i++) begin
      #1;
      if (result_valid) got = 1'b1;
      else begin
        if (stall_req) stalls++;
        @(negedge clk);
      end
    end
    check({tag, "_done"}, 64'(got), 64'd1);
    check({tag, "_res"}, result, exp);
    check({tag, "_stall"}, 64'(stalls), 64'(exp_stall));
    for (int h = 0; h < hold_n; h++) begin
      hold = 1'b1;
      @(negedge clk);
      #1;
      check({tag, "_hold_vld"}, 64'(result_valid), 64'd1);
      check({tag, "_hold_res"}, result, exp);
      check({tag, "_hold_stall"}, 64'(stall_req), 64'd0);
    end
    hold  = 1'b0;
    valid = 1'b0;
  endtask

  initial begin
    int seen;
    rst = 1'b1; valid = 1'b0; flush = 1'b0; hold = 1'b0;
    op = 4'd0; rs1 = '0; rs2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_stall", 64'(stall_req), 64'd0);
    check("rst_vld", 64'(result_valid), 64'd0);
    check("rst_res", result, 64'd0);

    do_op("mul", MD_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65, 0);
    @(negedge clk);
    #1;
    check("mul_vld_1cyc", 64'(result_valid), 64'd0);

    do_op("div", MD_DIV, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 65, 0);
    do_op("rem", MD_REM, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 65, 0);

    do_op("divu0", MD_DIVU, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    do_op("remu0", MD_REMU, 64'd5, 64'd0, 64'd5, 1, 0);
    do_op("div_ovf", MD_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1, 0);
    do_op("rem_ovf", MD_REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 0);

    do_op("divw", MD_DIVW, 64'h0000_0001_8000_0000, 64'd2, 64'hFFFF_FFFF_C000_0000, 33, 0);
    do_op("mulw", MD_MULW, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33, 0);
    do_op("divuw", MD_DIVUW, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33, 0);
    do_op("remuw", MD_REMUW, 64'hFFFF_FFFF_0000_0007, 64'd5, 64'd2, 33, 0);
    do_op("remw", MD_REMW, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33, 0);
    do_op("divw_ovf", MD_DIVW, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 0);
    do_op("remw0", MD_REMW, 64'h0000_0001_0000_0005, 64'hFFFF_FFFF_0000_0000, 64'd5, 1, 0);
    do_op("rsvd", 4'd13, 64'd9, 64'd9, 64'd0, 1, 0);

    // Abort a multiply part-way through; nothing may come out of it.
    @(negedge clk);
    valid = 1'b1; op = MD_MUL; rs1 = 64'd11; rs2 = 64'd13;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_stall", 64'(stall_req), 64'd0);
    check("flush_vld", 64'(result_valid), 64'd0);
    @(negedge clk);
    flush = 1'b0; valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      #1;
      if (result_valid) seen++;
      @(negedge clk);
    end
    check("flush_no_result", 64'(seen), 64'd0);
    do_op("mulhsu", MD_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);

    do_op("mulh_hold", MD_MULH, 64'h4000_0000_0000_0000, 64'd4, 64'd1, 65, 3);
    do_op("mulhu_b2b", MD_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 65, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
